// File: rtl/mem_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_unit_pkg
// Desc     : Command codes, FSM state encoding and command width for mem_unit.
// Options  : MEM_UNIT_BUMP_EN adds the RMW state used by BUP/BDN.
// Revision : 1.0 - initial release
// ============================================================================
package mem_unit_pkg;

    localparam int c_cmd_w = 3;

    localparam logic [c_cmd_w-1:0] c_cmd_nop = 3'd0;
    localparam logic [c_cmd_w-1:0] c_cmd_lda = 3'd1;
    localparam logic [c_cmd_w-1:0] c_cmd_ldi = 3'd2;
    localparam logic [c_cmd_w-1:0] c_cmd_wr  = 3'd3;
    localparam logic [c_cmd_w-1:0] c_cmd_bup = 3'd4;
    localparam logic [c_cmd_w-1:0] c_cmd_bdn = 3'd5;

    localparam int c_st_w = 2;

    localparam logic [c_st_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_st_w-1:0] c_st_ptr  = 2'd1;
    localparam logic [c_st_w-1:0] c_st_done = 2'd2;
`ifdef MEM_UNIT_BUMP_EN
    localparam logic [c_st_w-1:0] c_st_rmw  = 2'd3;
`endif

endpackage
`default_nettype wire

// File: rtl/mem_unit_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_unit_ram
// Desc     : Single-port RAM, synchronous write and read (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module mem_unit_ram #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    localparam int c_iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];

    // Callers never write out of range, so only the low index bits matter.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr[c_iw-1:0]] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr[c_iw-1:0]];
    end

endmodule
`default_nettype wire

// File: rtl/mem_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_unit
// Desc     : Address register + memory with direct/indirect load, write and
//            optional increment/decrement read-modify-write.
// Options  : MEM_UNIT_BUMP_EN enables BUP/BDN (otherwise they are undefined).
// Revision : 1.0 - initial release
// ============================================================================
module mem_unit #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 2**AW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [mem_unit_pkg::c_cmd_w-1:0] cmd,
    input  logic [AW-1:0]                    ADDR,
    input  logic [DW-1:0]                    R,
    output logic [AW-1:0]                    AR,
    output logic [DW-1:0]                    M,
    output logic                             done,
    output logic                             err
);
    import mem_unit_pkg::*;

    localparam logic [31:0] c_depth = 32'(DEPTH);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next;
    logic [AW-1:0]     r_ar;
    logic [AW-1:0]     w_ptr;
    logic [AW-1:0]     w_ram_addr;
    logic [DW-1:0]     r_m;
    logic [DW-1:0]     w_ram_q;
    logic [DW-1:0]     w_ram_wdata;
    logic              r_err;
    logic              r_load;
    logic              w_accept;
    logic              w_ram_we;
    logic              w_addr_bad;
    logic              w_ar_bad;
    logic              w_ptr_bad;

`ifdef MEM_UNIT_BUMP_EN
    logic              r_dec;
    logic [DW-1:0]     w_bumped;
    assign w_bumped = r_dec ? (w_ram_q - 1'b1) : (w_ram_q + 1'b1);
`endif

    generate
        if (DW >= AW) begin : g_ptr_trunc
            assign w_ptr = w_ram_q[AW-1:0];
        end else begin : g_ptr_ext
            assign w_ptr = {{(AW-DW){1'b0}}, w_ram_q};
        end
    endgenerate

    assign w_accept   = cmd_valid && (r_state == c_st_idle);
    assign w_addr_bad = 32'(ADDR) >= c_depth;
    assign w_ar_bad   = 32'(r_ar) >= c_depth;
    assign w_ptr_bad  = 32'(w_ptr) >= c_depth;
    assign AR         = r_ar;
    assign M          = r_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next = c_st_done;
                    if (cmd == c_cmd_ldi && !w_addr_bad) begin
                        w_next = c_st_ptr;
                    end
`ifdef MEM_UNIT_BUMP_EN
                    if ((cmd == c_cmd_bup || cmd == c_cmd_bdn) && !w_ar_bad) begin
                        w_next = c_st_rmw;
                    end
`endif
                end
            end
            c_st_ptr:  w_next = c_st_done;
`ifdef MEM_UNIT_BUMP_EN
            c_st_rmw:  w_next = c_st_done;
`endif
            c_st_done: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // RAM write enable is decoded from state, so an async reset in RMW
    // drops the write before the next clock edge.
    always_comb begin
        cmd_ready   = (r_state == c_st_idle);
        done        = (r_state == c_st_done);
        err         = (r_state == c_st_done) && r_err;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_ar;
        w_ram_wdata = R;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (cmd == c_cmd_lda || cmd == c_cmd_ldi) begin
                        w_ram_addr = ADDR;
                    end
                    if (cmd == c_cmd_wr && !w_ar_bad) begin
                        w_ram_we = 1'b1;
                    end
                end
            end
            c_st_ptr: w_ram_addr = w_ptr;
`ifdef MEM_UNIT_BUMP_EN
            c_st_rmw: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = w_bumped;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar   <= '0;
            r_m    <= '0;
            r_err  <= 1'b0;
            r_load <= 1'b0;
`ifdef MEM_UNIT_BUMP_EN
            r_dec  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_err  <= 1'b0;
                        r_load <= 1'b0;
                        case (cmd)
                            c_cmd_nop: ;
                            c_cmd_lda: begin
                                if (w_addr_bad) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_ar   <= ADDR;
                                    r_load <= 1'b1;
                                end
                            end
                            c_cmd_ldi: begin
                                if (w_addr_bad) r_err <= 1'b1;
                                else            r_load <= 1'b1;
                            end
                            c_cmd_wr: begin
                                if (w_ar_bad) r_err <= 1'b1;
                                else          r_m   <= R;
                            end
`ifdef MEM_UNIT_BUMP_EN
                            c_cmd_bup, c_cmd_bdn: begin
                                if (w_ar_bad) r_err <= 1'b1;
                                else          r_dec <= (cmd == c_cmd_bdn);
                            end
`endif
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                c_st_ptr: begin
                    if (w_ptr_bad) r_err <= 1'b1;
                    else           r_ar  <= w_ptr;
                end
`ifdef MEM_UNIT_BUMP_EN
                c_st_rmw: r_m <= w_bumped;
`endif
                c_st_done: begin
                    if (r_err)       r_m <= '0;
                    else if (r_load) r_m <= w_ram_q;
                end
                default: ;
            endcase
        end
    end

    mem_unit_ram #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_unit
// Desc     : Directed bench for mem_unit (full-depth and DEPTH=128 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_unit;

    localparam logic [2:0] NOP = 3'd0, LDA = 3'd1, LDI = 3'd2, WR = 3'd3,
                           BUP = 3'd4, BDN = 3'd5, BAD = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic [7:0] addr = 8'd0, wdat = 8'd0;
    logic       rdy0, rdy1, done0, done1, err0, err1;
    logic [7:0] ar0, ar1, m0, m1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_unit u0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0), .cmd(cmd),
        .ADDR(addr), .R(wdat), .AR(ar0), .M(m0), .done(done0), .err(err0)
    );

    mem_unit #(.DEPTH(128)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd(cmd),
        .ADDR(addr), .R(wdat), .AR(ar1), .M(m1), .done(done1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure negedges until done, check err and return to ready.
    task automatic do_cmd(input bit sel, input logic [2:0] c, input logic [7:0] a,
                          input logic [7:0] d, input int exp_lat, input logic exp_err,
                          input string tag);
        int lat;
        @(negedge clk);
        cmd = c; addr = a; wdat = d;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(negedge clk);
            if (sel ? done1 : done0) lat = i;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".err"}, sel ? err1 : err0, exp_err);
        @(negedge clk);
        check({tag, ".rdy"}, sel ? {rdy1, done1, err1} : {rdy0, done0, err0}, 3'b100);
    endtask

    initial begin
        int n;
        int dones;

        repeat (2) @(posedge clk);
        #1;
        check("rst.state", {rdy0, done0, err0}, 3'b100);
        check("rst.ar", ar0, 8'h00);
        check("rst.m", m0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        do_cmd(0, LDA, 8'h01, 8'h00, 1, 1'b0, "lda1");
        check("lda1.ar", ar0, 8'h01);
        do_cmd(0, WR, 8'h00, 8'h02, 1, 1'b0, "wr1");
        check("wr1.m", m0, 8'h02);
        do_cmd(0, LDA, 8'h02, 8'h00, 1, 1'b0, "lda2");
        do_cmd(0, WR, 8'h00, 8'h0a, 1, 1'b0, "wr2");
        check("wr2.ar", ar0, 8'h02);
        check("wr2.m", m0, 8'h0a);
        do_cmd(0, LDA, 8'h01, 8'h00, 1, 1'b0, "rd1");
        check("rd1.m", m0, 8'h02);

        do_cmd(0, LDI, 8'h01, 8'h00, 2, 1'b0, "ldi");
        check("ldi.ar", ar0, 8'h02);
        check("ldi.m", m0, 8'h0a);

        do_cmd(0, LDA, 8'h03, 8'h00, 1, 1'b0, "lda3");
        do_cmd(0, WR, 8'h00, 8'h33, 1, 1'b0, "wr3");
        do_cmd(0, LDA, 8'h05, 8'h00, 1, 1'b0, "lda5");
        do_cmd(0, WR, 8'h00, 8'hff, 1, 1'b0, "wr5");
`ifdef MEM_UNIT_BUMP_EN
        do_cmd(0, BUP, 8'h00, 8'h00, 2, 1'b0, "bup");
        check("bup.m", m0, 8'h00);
        do_cmd(0, LDA, 8'h05, 8'h00, 1, 1'b0, "rd5a");
        check("rd5a.m", m0, 8'h00);
        do_cmd(0, BDN, 8'h00, 8'h00, 2, 1'b0, "bdn");
        check("bdn.m", m0, 8'hff);
`else
        do_cmd(0, BUP, 8'h00, 8'h00, 1, 1'b1, "bup");
        check("bup.m", m0, 8'h00);
        check("bup.ar", ar0, 8'h05);
        do_cmd(0, LDA, 8'h05, 8'h00, 1, 1'b0, "rd5a");
        check("rd5a.m", m0, 8'hff);
`endif

        do_cmd(0, NOP, 8'h01, 8'h77, 1, 1'b0, "nop");
        check("nop.arm", {ar0, m0}, 16'h05ff);
        do_cmd(0, BAD, 8'h01, 8'h77, 1, 1'b1, "undef");
        check("undef.ar", ar0, 8'h05);
        do_cmd(0, LDA, 8'hff, 8'h00, 1, 1'b0, "ldaff");
        check("ldaff.ar", ar0, 8'hff);
        do_cmd(0, LDA, 8'h05, 8'h00, 1, 1'b0, "rd5b");

        // LDA 3 held valid while BUP is in flight.
        @(negedge clk);
        cmd = BUP; v0 = 1'b1;
        @(posedge clk); #1;
        cmd = LDA; addr = 8'h03;
        n = 0; dones = 0;
        for (int i = 1; i <= 8 && dones < 2; i++) begin
            @(negedge clk);
            if (done0) begin
                dones++;
                if (dones == 1) check("hold.ar1", ar0, 8'h05);
                if (dones == 2) begin
                    n = i;
                    v0 = 1'b0;
                end
            end
        end
`ifdef MEM_UNIT_BUMP_EN
        check("hold.n", n, 4);
`else
        check("hold.n", n, 3);
`endif
        @(negedge clk);
        check("hold.ar", ar0, 8'h03);
        check("hold.m", m0, 8'h33);
        check("hold.idle", {rdy0, done0}, 2'b10);

        // Reset during the pointer-read cycle of LDI.
        @(negedge clk);
        cmd = LDI; addr = 8'h01; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rptr.state", {rdy0, done0, err0}, 3'b100);
        check("rptr.arm", {ar0, m0}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || err0) dones++;
        end
        check("rptr.nodone", dones, 0);
        do_cmd(0, LDA, 8'h02, 8'h00, 1, 1'b0, "keep");
        check("keep.m", m0, 8'h0a);

`ifdef MEM_UNIT_BUMP_EN
        // Reset during RMW must suppress the write-back (mem[5] is 0x00 here).
        do_cmd(0, LDA, 8'h05, 8'h00, 1, 1'b0, "pre");
        check("pre.m", m0, 8'h00);
        @(negedge clk);
        cmd = BUP; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rrmw.ar", ar0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(0, LDA, 8'h05, 8'h00, 1, 1'b0, "post");
        check("post.m", m0, 8'h00);
`endif

        // DEPTH=128 instance: out-of-range direct and indirect access.
        do_cmd(1, LDA, 8'h10, 8'h00, 1, 1'b0, "d.lda");
        do_cmd(1, WR, 8'h00, 8'h90, 1, 1'b0, "d.wr");
        check("d.wr.m", m1, 8'h90);
        do_cmd(1, LDA, 8'h80, 8'h00, 1, 1'b1, "d.oor");
        check("d.oor.ar", ar1, 8'h10);
        check("d.oor.m", m1, 8'h00);
        do_cmd(1, LDI, 8'h10, 8'h00, 2, 1'b1, "d.ptr");
        check("d.ptr.arm", {ar1, m1}, 16'h1000);
        do_cmd(1, LDA, 8'h7f, 8'h00, 1, 1'b0, "d.top");
        check("d.top.ar", ar1, 8'h7f);
        do_cmd(1, LDA, 8'h10, 8'h00, 1, 1'b0, "d.rd");
        check("d.rd.m", m1, 8'h90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
